// File: rtl/soc_system_hps_result_0.sv
// ---------------------------------------------------------------------------
// soc_system_hps_result_0
//
// FPGA-to-HPS return-data port. Result words arrive from the AES datapath
// over a valid/ready handshake and are queued in a small FIFO. The HPS reads
// them back through a zero-wait-state Avalon-MM slave on the lightweight
// bridge, polls status, and can be interrupted on not-empty / underflow.
//
// Ports:
//   clk, reset        single clock; asynchronous active-high reset
//   address[1:0]      Avalon word address (0 DATA, 1 STATUS, 2 IRQ_MASK, 3 -)
//   chipselect        Avalon select
//   read_n, write_n   Avalon strobes, active-low
//   writedata[31:0]   Avalon write data
//   readdata[31:0]    Avalon read data, combinational (latency 0)
//   in_data[WIDTH-1:0], in_valid, in_ready   datapath push handshake
//   irq               level interrupt, driven only from registers
// ---------------------------------------------------------------------------
module soc_system_hps_result_0 #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       mask_q, mask_d;
    logic             underflow_q, underflow_d;

    // Storage is deliberately left out of reset; pointers and count define
    // which entries are meaningful.
    logic [WIDTH-1:0] mem [DEPTH];

    logic full, empty;
    logic rd_sel, wr_sel;
    logic push, pop, uflow;
    logic [31:0] head_ext;
    logic [31:0] status_word;

    // Only these writedata bits have meaning; the rest are intentionally dropped.
    logic unused_writedata;
    assign unused_writedata = ^{writedata[31:11], writedata[9:2]};

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign rd_sel = chipselect & ~read_n;
    assign wr_sel = chipselect & ~write_n;

    // in_ready is forced low during reset so an in-flight handshake is dropped.
    assign in_ready = ~full & ~reset;
    assign push     = in_valid & in_ready;
    assign pop      = rd_sel & (address == 2'd0) & ~empty;
    assign uflow    = rd_sel & (address == 2'd0) & empty;

    assign irq = (mask_q[0] & ~empty) | (mask_q[1] & underflow_q);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mask_d      = mask_q;
        underflow_d = underflow_q;

        // Pointer arithmetic wraps naturally because DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_sel && address == 2'd2) begin
            mask_d = writedata[1:0];
        end
        // The clear (address 1) and the set (address 0) can never coincide.
        if (wr_sel && address == 2'd1 && writedata[10]) begin
            underflow_d = 1'b0;
        end
        if (uflow) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mask_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mask_q      <= mask_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        head_ext = '0;
        if (!empty) begin
            head_ext[WIDTH-1:0] = mem[rd_ptr_q];
        end
        status_word             = '0;
        status_word[CW-1:0]     = count_q;
        status_word[8]          = empty;
        status_word[9]          = full;
        status_word[10]         = underflow_q;
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata = head_ext;
                2'd1:    readdata = status_word;
                2'd2:    readdata = {30'd0, mask_q};
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_system_hps_result_0.sv
// ---------------------------------------------------------------------------
// Directed testbench for soc_system_hps_result_0 (DEPTH=4, WIDTH=32).
// Inputs change 1 time unit after a rising edge; outputs are sampled one
// more unit later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_soc_system_hps_result_0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    soc_system_hps_result_0 #(.DEPTH(4), .WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .irq        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle bus read; returns readdata sampled mid-cycle, irq alongside.
    task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic irq_s);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        #1;
        d     = readdata;
        irq_s = irq;
        next_cycle();
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
        address    = a;
        writedata  = wd;
        chipselect = 1'b1;
        write_n    = 1'b0;
        next_cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic push(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
    endtask

    logic [31:0] rd;
    logic        irq_s;

    initial begin
        // ---- reset state ----
        next_cycle();
        next_cycle();
        chipselect = 1'b1;
        address    = 2'd1;
        #1;
        chk("rst_status", readdata, 32'h100);
        address = 2'd0;
        #1;
        chk("rst_data", readdata, 32'h0);
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        in_valid   = 1'b0;
        chipselect = 1'b0;
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // ---- single push with not-empty interrupt ----
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, rd, irq_s);
        chk("mask_rb", rd, 32'h1);
        push(32'hA5A5_0001);
        bus_read(2'd1, rd, irq_s);
        chk("t1_status", rd, 32'h001);
        chk("t1_irq", {31'd0, irq_s}, 32'h1);
        bus_read(2'd0, rd, irq_s);
        chk("t1_data", rd, 32'hA5A5_0001);
        bus_read(2'd1, rd, irq_s);
        chk("t1_status_after", rd, 32'h100);
        chk("t1_irq_after", {31'd0, irq_s}, 32'h0);
        bus_read(2'd3, rd, irq_s);
        chk("addr3", rd, 32'h0);

        // ---- fill with in_valid held, drain across pointer wrap ----
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h10 + 32'(i);
            next_cycle();
        end
        chk("t2_in_ready_full", {31'd0, in_ready}, 32'h0);
        in_valid = 1'b0;
        bus_read(2'd1, rd, irq_s);
        chk("t2_status_full", rd, 32'h204);
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd0, rd, irq_s);
            chk($sformatf("t2_data%0d", i), rd, 32'h10 + 32'(i));
        end

        // ---- pop while full with in_valid: push deferred one cycle ----
        for (int i = 0; i < 4; i++) push(32'h20 + 32'(i));
        in_data    = 32'h24;
        in_valid   = 1'b1;
        address    = 2'd0;
        chipselect = 1'b1;
        read_n     = 1'b0;
        #1;
        chk("t3_pop_data", readdata, 32'h20);
        chk("t3_in_ready_full", {31'd0, in_ready}, 32'h0);
        next_cycle();
        chipselect = 1'b0;
        read_n     = 1'b1;
        #1;
        chk("t3_in_ready_back", {31'd0, in_ready}, 32'h1);
        address    = 2'd1;
        chipselect = 1'b1;
        #1;
        chk("t3_status_cnt3", readdata, 32'h003);
        chipselect = 1'b0;
        next_cycle();
        in_valid = 1'b0;
        bus_read(2'd1, rd, irq_s);
        chk("t3_status_cnt4", rd, 32'h204);
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd0, rd, irq_s);
            chk($sformatf("t3_data%0d", i), rd, 32'h21 + 32'(i));
        end

        // ---- simultaneous push/pop at count=2 ----
        push(32'h30);
        push(32'h31);
        for (int i = 0; i < 6; i++) begin
            in_data    = 32'h32 + 32'(i);
            in_valid   = 1'b1;
            address    = 2'd0;
            chipselect = 1'b1;
            read_n     = 1'b0;
            #1;
            chk($sformatf("t4_pp_data%0d", i), readdata, 32'h30 + 32'(i));
            next_cycle();
        end
        in_valid   = 1'b0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        bus_read(2'd1, rd, irq_s);
        chk("t4_status", rd, 32'h002);
        bus_read(2'd0, rd, irq_s);
        chk("t4_tail0", rd, 32'h36);
        bus_read(2'd0, rd, irq_s);
        chk("t4_tail1", rd, 32'h37);

        // ---- underflow and its interrupt ----
        bus_write(2'd2, 32'h2);
        bus_read(2'd0, rd, irq_s);
        chk("t5_uflow_data", rd, 32'h0);
        bus_read(2'd1, rd, irq_s);
        chk("t5_status_uflow", rd, 32'h500);
        chk("t5_irq_uflow", {31'd0, irq_s}, 32'h1);
        bus_write(2'd1, 32'h400);
        bus_read(2'd1, rd, irq_s);
        chk("t5_status_clr", rd, 32'h100);
        chk("t5_irq_clr", {31'd0, irq_s}, 32'h0);

        // ---- underflow read in the same cycle as a push ----
        in_data  = 32'h55;
        in_valid = 1'b1;
        bus_read(2'd0, rd, irq_s);
        in_valid = 1'b0;
        chk("t5b_data", rd, 32'h0);
        bus_read(2'd1, rd, irq_s);
        chk("t5b_status", rd, 32'h401);
        bus_write(2'd1, 32'h400);
        bus_read(2'd0, rd, irq_s);
        chk("t5b_landed", rd, 32'h55);

        // ---- asynchronous reset mid-cycle ----
        bus_write(2'd2, 32'h1);
        push(32'h61);
        push(32'h62);
        in_data  = 32'h63;
        in_valid = 1'b1;
        #1;
        chk("t6_irq_pre", {31'd0, irq}, 32'h1);
        chk("t6_in_ready_pre", {31'd0, in_ready}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_in_ready_rst", {31'd0, in_ready}, 32'h0);
        chk("t6_irq_rst", {31'd0, irq}, 32'h0);
        next_cycle();
        in_valid = 1'b0;
        reset    = 1'b0;
        next_cycle();
        bus_read(2'd1, rd, irq_s);
        chk("t6_status_post", rd, 32'h100);
        bus_read(2'd0, rd, irq_s);
        chk("t6_data_post", rd, 32'h0);
        bus_read(2'd2, rd, irq_s);
        chk("t6_mask_post", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
